// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with REQ/WAIT/HOLD handshake, delay-slot
//            branch handling and exception redirects.
// Options  : FETCH_ADDR_CHECK_EN enables misaligned-fetch detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        except_valid,
  input  logic [31:0] except_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ctrl_instrD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
  output logic        instr_validF,
  output logic        F_change,
  output logic        fetch_stall,
  output logic        excep_adelF
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [1:0] LSB_KEEP = 2'b11;
`else
  localparam logic [1:0] LSB_KEEP = 2'b00;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        discard_q, discard_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        misalign;

`ifdef FETCH_ADDR_CHECK_EN
  assign misalign = |addr_q[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    adel_d     = adel_q;
    discard_d  = discard_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;

    // A branch behind an outstanding exception redirect is already flushed.
    if (branch_taken && !except_valid && !discard_q) begin
      redir_d    = 1'b1;
      redir_pc_d = branch_target;
    end

    case (state_q)
      S_REQ: begin
        if (misalign) begin
          if (except_valid) begin
            addr_d  = except_pc;
            redir_d = 1'b0;
          end else begin
            state_d = S_HOLD;
            pc_d    = addr_q;
            instr_d = 32'd0;
            adel_d  = 1'b1;
          end
        end else begin
          if (except_valid) begin
            discard_d  = 1'b1;
            redir_d    = 1'b1;
            redir_pc_d = except_pc;
          end
          if (inst_addr_ok) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (except_valid) begin
          discard_d  = 1'b1;
          redir_d    = 1'b1;
          redir_pc_d = except_pc;
        end
        if (inst_data_ok) begin
          if (discard_q || except_valid) begin
            state_d   = S_REQ;
            addr_d    = except_valid ? except_pc : redir_pc_q;
            discard_d = 1'b0;
            redir_d   = 1'b0;
          end else begin
            state_d = S_HOLD;
            pc_d    = addr_q;
            instr_d = inst_rdata;
            adel_d  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (except_valid) begin
          state_d = S_REQ;
          addr_d  = except_pc;
          redir_d = 1'b0;
        end else if (!stallF) begin
          state_d = S_REQ;
          if (branch_taken) begin
            addr_d = branch_target;
          end else if (redir_q) begin
            addr_d = redir_pc_q;
          end else begin
            addr_d = pc_q + 32'd4;
          end
          redir_d = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      addr_q     <= {RESET_PC[31:2], RESET_PC[1:0] & LSB_KEEP};
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      adel_q     <= 1'b0;
      discard_q  <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= {addr_d[31:2], addr_d[1:0] & LSB_KEEP};
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      adel_q     <= adel_d;
      discard_q  <= discard_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign inst_req     = (state_q == S_REQ) && !misalign;
  assign inst_addr    = addr_q;
  assign pcF          = pc_q;
  assign pc_plus4F    = pc_q + 32'd4;
  assign instrF       = instr_q;
  assign instr_validF = (state_q == S_HOLD);
  assign F_change     = ctrl_instrD && instr_validF;
  assign fetch_stall  = !instr_validF;
  assign excep_adelF  = adel_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage with an instruction-memory
//            responder returning ~address as instruction data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stallF, except_valid, branch_taken, ctrl_instrD;
  logic [31:0] except_pc, branch_target;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] pcF, pc_plus4F, instrF;
  logic        instr_validF, F_change, fetch_stall, excep_adelF;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .stallF(stallF),
    .except_valid(except_valid), .except_pc(except_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ctrl_instrD(ctrl_instrD),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .pcF(pcF), .pc_plus4F(pc_plus4F), .instrF(instrF),
    .instr_validF(instr_validF), .F_change(F_change),
    .fetch_stall(fetch_stall), .excep_adelF(excep_adelF)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic        fchg;
    logic        adel;
  } inst_exp_t;

  logic [31:0] exp_addr_q[$];
  inst_exp_t   exp_inst_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] pcp4,
                           input logic [31:0] instr, input logic fchg, input logic adel);
    inst_exp_t e;
    e.pc = pc; e.pcp4 = pcp4; e.instr = instr; e.fchg = fchg; e.adel = adel;
    exp_inst_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (inst_req && inst_addr_ok && inst_addr == a) found = 1;
    end
    if (!found) chk("timeout_accept", 32'd0, a);
  endtask

  task automatic wait_valid();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (instr_validF) found = 1;
    end
    if (!found) chk("timeout_valid", {31'd0, instr_validF}, 32'd1);
  endtask

  // Memory responder: accepts when idle, returns ~addr after dly extra cycles.
  initial begin : responder
    bit          busy;
    int          cnt;
    logic [31:0] la;
    busy = 0; cnt = 0; la = 32'd0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = ~la;
          busy         = 0;
        end else begin
          cnt--;
        end
      end else if (inst_req && !rst) begin
        inst_addr_ok = 1'b1;
        la           = inst_addr;
        busy         = 1;
        cnt          = dly;
      end
    end
  end

  initial begin : monitor
    logic      pv;
    inst_exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_req && inst_addr_ok) begin
          if (exp_addr_q.size() == 0) chk("unexpected_request", inst_addr, 32'hXXXX_XXXX);
          else chk("inst_addr", inst_addr, exp_addr_q.pop_front());
        end
        if (instr_validF && !pv) begin
          if (exp_inst_q.size() == 0) begin
            chk("unexpected_delivery", pcF, 32'hXXXX_XXXX);
          end else begin
            e = exp_inst_q.pop_front();
            chk("pcF", pcF, e.pc);
            chk("pc_plus4F", pc_plus4F, e.pcp4);
            chk("instrF", instrF, e.instr);
            chk("F_change", {31'd0, F_change}, {31'd0, e.fchg});
            chk("excep_adelF", {31'd0, excep_adelF}, {31'd0, e.adel});
          end
        end
      end
      pv = instr_validF;
    end
  end

  initial begin : stimulus
    int k;
    rst = 1'b1; stallF = 1'b1; except_valid = 1'b0; except_pc = 32'd0;
    branch_taken = 1'b0; branch_target = 32'd0; ctrl_instrD = 1'b0;

    // Reset release, first fetch and stall hold
    exp_addr_q.push_back(32'hBFC0_0000);
    push_inst(32'hBFC0_0000, 32'hBFC0_0004, 32'h403F_FFFF, 1'b0, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0004);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pcF", pcF, 32'hBFC0_0000);
    chk("rst_pc_plus4F", pc_plus4F, 32'hBFC0_0004);
    chk("rst_instrF", instrF, 32'd0);
    chk("rst_valid", {31'd0, instr_validF}, 32'd0);
    chk("rst_adel", {31'd0, excep_adelF}, 32'd0);
    chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(negedge clk);
      if (instr_validF) k = i;
    end
    chk("valid_latency", k, 32'd3);
    chk("hold_req0", {31'd0, inst_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("stall_pcF", pcF, 32'hBFC0_0000);
      chk("stall_instrF", instrF, 32'h403F_FFFF);
      chk("stall_valid", {31'd0, instr_validF}, 32'd1);
      chk("stall_req", {31'd0, inst_req}, 32'd0);
    end
    tick(); stallF = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("release_req", {31'd0, inst_req}, 32'd1);
    chk("release_addr", inst_addr, 32'hBFC0_0004);

    // Branch resolved while delay slot is in WAIT; exception during WAIT
    push_inst(32'hBFC0_0004, 32'hBFC0_0008, 32'h403F_FFFB, 1'b0, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0008);
    push_inst(32'hBFC0_0008, 32'hBFC0_000C, 32'h403F_FFF7, 1'b1, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0100);
    push_inst(32'hBFC0_0100, 32'hBFC0_0104, 32'h403F_FEFF, 1'b0, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0104);
    exp_addr_q.push_back(32'hBFC0_0380);
    push_inst(32'hBFC0_0380, 32'hBFC0_0384, 32'h403F_FC7F, 1'b0, 1'b0);
    dly = 1;
    wait_acc(32'hBFC0_0008);
    tick(); branch_taken = 1'b1; branch_target = 32'hBFC0_0100; ctrl_instrD = 1'b1;
    tick(); branch_taken = 1'b0;
    wait_valid();
    tick(); ctrl_instrD = 1'b0;
    wait_acc(32'hBFC0_0104);
    tick(); except_valid = 1'b1; except_pc = 32'hBFC0_0380; stallF = 1'b1;
    tick(); except_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("discard_valid", {31'd0, instr_validF}, 32'd0);
    chk("discard_addr", inst_addr, 32'hBFC0_0380);

    // Exception and branch together in HOLD: exception wins
    exp_addr_q.push_back(32'hBFC0_0200);
    push_inst(32'hBFC0_0200, 32'hBFC0_0204, 32'h403F_FDFF, 1'b0, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0204);
    push_inst(32'hBFC0_0204, 32'hBFC0_0208, 32'h403F_FDFB, 1'b0, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0208);
    wait_valid();
    tick(); except_valid = 1'b1; except_pc = 32'hBFC0_0200;
    branch_taken = 1'b1; branch_target = 32'hBFC0_0300; stallF = 1'b0;
    tick(); except_valid = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    chk("hold_exc_valid", {31'd0, instr_validF}, 32'd0);
    chk("hold_exc_addr", inst_addr, 32'hBFC0_0200);

    // Reset while in WAIT, late data_ok afterwards
    exp_addr_q.push_back(32'hBFC0_0000);
    push_inst(32'hBFC0_0000, 32'hBFC0_0004, 32'h403F_FFFF, 1'b0, 1'b0);
    dly = 4;
    wait_acc(32'hBFC0_0208);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_wait_pcF", pcF, 32'hBFC0_0000);
    chk("rst_wait_valid", {31'd0, instr_validF}, 32'd0);
    tick(); rst = 1'b0; stallF = 1'b1; dly = 0;
    k = 0;
    for (int i = 0; i < 10 && k == 0; i++) begin
      @(negedge clk);
      if (inst_data_ok) k = 1;
    end
    chk("late_data_seen", k, 32'd1);
    chk("late_data_req", {31'd0, inst_req}, 32'd1);
    chk("late_data_valid", {31'd0, instr_validF}, 32'd0);
    @(negedge clk);
    chk("late_data_addr", inst_addr, 32'hBFC0_0000);

    // Redirect to the top of the address space: PC+4 wraps to zero
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_inst(32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0003, 1'b0, 1'b0);
    exp_addr_q.push_back(32'h0000_0000);
    push_inst(32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_valid();
    tick(); except_valid = 1'b1; except_pc = 32'hFFFF_FFFC; stallF = 1'b0;
    tick(); except_valid = 1'b0;
    wait_acc(32'h0000_0000);
    tick(); stallF = 1'b1;

    // Misaligned redirect target
`ifdef FETCH_ADDR_CHECK_EN
    push_inst(32'hBFC0_0382, 32'hBFC0_0386, 32'h0000_0000, 1'b0, 1'b1);
`else
    exp_addr_q.push_back(32'hBFC0_0380);
    push_inst(32'hBFC0_0380, 32'hBFC0_0384, 32'h403F_FC7F, 1'b0, 1'b0);
`endif
    wait_valid();
    tick(); except_valid = 1'b1; except_pc = 32'hBFC0_0382;
    tick(); except_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_ADDR_CHECK_EN
    chk("misalign_no_req", {31'd0, inst_req}, 32'd0);
`else
    chk("aligned_addr", inst_addr, 32'hBFC0_0380);
`endif

    for (int i = 0; i < 100 && (exp_addr_q.size() != 0 || exp_inst_q.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("addr_queue_left", exp_addr_q.size(), 32'd0);
    chk("inst_queue_left", exp_inst_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
